// File: rtl/avr_io_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : avr_io_arbiter_pkg
// Desc   : Shared IO bus widths, requester ids and FSM state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
package avr_io_arbiter_pkg;

    localparam int unsigned c_addr_w = 6;
    localparam int unsigned c_data_w = 8;

    localparam logic c_id_a = 1'b0;
    localparam logic c_id_b = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/avr_io_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : avr_io_rr_arb
// Desc   : Two-way grant (round-robin or fixed A priority) with pointer.
// Rev    : 1.0 - initial release
// ============================================================================
module avr_io_rr_arb
    import avr_io_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_id
);

    // Pointer names the requester that wins the next contention.
    logic r_ptr;

    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_id    = c_id_a;
        if (req_a && req_b) begin
            gnt_id = RR_ENABLE ? r_ptr : c_id_a;
        end else if (req_b) begin
            gnt_id = c_id_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= c_id_a;
        end else if (take && gnt_valid) begin
            r_ptr <= ~gnt_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avr_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module : avr_io_arbiter
// Desc   : Shares the 6-bit/8-bit AVR IO bus between CPU (A) and debug/DMA (B).
// Rev    : 1.0 - initial release
// ============================================================================
module avr_io_arbiter
    import avr_io_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [c_addr_w-1:0] a_addr,
    input  logic [c_data_w-1:0] a_wdata,
    output logic                a_ack,
    output logic [c_data_w-1:0] a_rdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [c_addr_w-1:0] b_addr,
    input  logic [c_data_w-1:0] b_wdata,
    output logic                b_ack,
    output logic [c_data_w-1:0] b_rdata,
    output logic [c_addr_w-1:0] io_addr,
    inout  wire  [c_data_w-1:0] io_data,
    output logic                io_write,
    output logic                io_read,
    output logic                busy
);

    state_t              r_state;
    state_t              w_next;
    logic                w_take;
    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic                w_win_we;
    logic [c_addr_w-1:0] w_win_addr;
    logic [c_data_w-1:0] w_win_wdata;

    logic                r_gid;
    logic [c_data_w-1:0] r_wdata;
    logic [c_addr_w-1:0] r_io_addr;
    logic                r_io_write;
    logic                r_io_read;
    logic                r_busy;
    logic                r_a_ack;
    logic                r_b_ack;
    logic [c_data_w-1:0] r_a_rdata;
    logic [c_data_w-1:0] r_b_rdata;

    avr_io_rr_arb #(
        .RR_ENABLE (RR_ENABLE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_a     (a_req),
        .req_b     (b_req),
        .take      (w_take),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_comb begin
        w_win_we    = (w_gnt_id == c_id_b) ? b_we    : a_we;
        w_win_addr  = (w_gnt_id == c_id_b) ? b_addr  : a_addr;
        w_win_wdata = (w_gnt_id == c_id_b) ? b_wdata : a_wdata;
    end

    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_take = 1'b1;
                    w_next = w_win_we ? ST_WR : ST_RD1;
                end
            end
            ST_WR:   w_next = ST_ACK;
            ST_RD1:  w_next = ST_RD2;
            ST_RD2:  w_next = ST_ACK;
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gid      <= c_id_a;
            r_wdata    <= '0;
            r_io_addr  <= '0;
            r_io_write <= 1'b0;
            r_io_read  <= 1'b0;
            r_busy     <= 1'b0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            if (w_take) begin
                r_gid     <= w_gnt_id;
                r_wdata   <= w_win_wdata;
                r_io_addr <= w_win_addr;
            end
            r_io_write <= (w_next == ST_WR);
            r_io_read  <= (w_next == ST_RD1) || (w_next == ST_RD2);
            r_busy     <= (w_next != ST_IDLE);
            r_a_ack    <= (w_next == ST_ACK) && (r_gid == c_id_a);
            r_b_ack    <= (w_next == ST_ACK) && (r_gid == c_id_b);
            if (r_state == ST_RD2) begin
                if (r_gid == c_id_a) begin
                    r_a_rdata <= io_data;
                end else begin
                    r_b_rdata <= io_data;
                end
            end
        end
    end

    assign io_data  = (r_state == ST_WR) ? r_wdata : 'z;
    assign io_addr  = r_io_addr;
    assign io_write = r_io_write;
    assign io_read  = r_io_read;
    assign busy     = r_busy;
    assign a_ack    = r_a_ack;
    assign b_ack    = r_b_ack;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;

endmodule
`default_nettype wire
